conv_acc_stage: RTL and testbench
=================================

Name: conv_acc_stage

Overview:
Downstream of the 9-tap multiplier PE. Consumes the PE's nine 32-bit signed products per output pixel and reduces them through a pipelined adder tree, then adds a per-channel bias. The result is rounded, shifted, saturated and optionally ReLU'd to a 16-bit signed pixel. A valid/ready handshake lets the output writer apply backpressure. The block also counts emitted pixels and pulses `done` at the end of each frame.

Parameters:
- `SHIFT`, 8, arithmetic right shift applied to the accumulated sum (fixed-point rescale), range 0..20.
- `NUM_OUT`, 4096, number of output pixels per frame (`done` pulses on the last one).
- `CNT_W`, 12, width of the pixel counter; must satisfy 2^CNT_W >= NUM_OUT.

Ports:
- `clk`, input, 1: system clock, all logic on the rising edge.
- `rst_n`, input, 1: synchronous active-low reset.
- `in_valid`, input, 1: `product_in` / `bias_in` / `relu_en` valid this cycle.
- `in_ready`, output, 1: stage accepts input this cycle.
- `product_in`, input, 288: 9 signed 32-bit products; product i is at bits [i*32+31 : i*32].
- `bias_in`, input, 32: signed bias, added at the same scale as the products.
- `relu_en`, input, 1: travels with the data; 1 means clamp negative results to 0.
- `out_valid`, output, 1: `pixel_out` valid.
- `out_ready`, input, 1: downstream accepts `pixel_out`.
- `pixel_out`, output, 16: signed result pixel.
- `sat_out`, output, 1: qualifies `pixel_out`; 1 if the result was saturated.
- `pix_cnt`, output, `CNT_W`: number of pixels accepted downstream in the current frame.
- `done`, output, 1: single-cycle pulse on the cycle the `NUM_OUT`-th pixel is accepted.

Behaviour:
- Reset (`rst_n`=0 at a clock edge):
  - All stage valid bits clear.
  - `out_valid`=0, `pixel_out`=0, `sat_out`=0, `pix_cnt`=0, `done`=0.
  - Data in flight is discarded; no partial pixel is emitted after reset.
- Pipeline: 4 register stages, each with a valid bit; the relu bit travels alongside the data. Global advance `adv = ~out_valid | out_ready`.
  - `in_ready = adv`, combinational. An input is accepted when `in_valid & in_ready`.
  - When `adv`=0, every stage holds its contents and `pixel_out` stays stable; handshake rule: data must not change while `out_valid & ~out_ready`.
  - Bubbles (`in_valid`=0) propagate as invalid stages.
  - Latency: 4 cycles from acceptance to `out_valid` with no stall. Throughput: 1 pixel per cycle.
- S1: four pair sums p0+p1, p2+p3, p4+p5, p6+p7, each 33-bit sign-extended. p8 + bias is summed at 33 bits.
- S2: two 34-bit sums, (s01+s23) and (s45+s67). The S1 p8+bias term is carried forward.
- S3: `acc` = sum of all terms, sign-extended to 37 bits. No overflow is possible at this width.
- S4 (output register):
  - If `SHIFT`>0: `r = (acc + 2^(SHIFT-1)) >>> SHIFT`. This is round-half-up toward +inf; e.g. -1.5 rounds to -1.
  - If `SHIFT`=0: `r = acc`.
  - Saturate r to [-32768, 32767]; `sat_out`=1 if clamping occurred.
  - Then, if relu is set and the result is negative, the output is 0. ReLU alone does not set `sat_out`.
- Counter:
  - On each output handshake (`out_valid & out_ready`), `pix_cnt` increments.
  - If `pix_cnt` = `NUM_OUT`-1 at the handshake: `pix_cnt` wraps to 0 and `done`=1 for the following cycle only.
  - `done` is registered and is deasserted the cycle after it pulses.
- Simultaneous events:
  - An input accepted in the same cycle as an output handshake: both take effect; the pipeline shifts by one.
  - `rst_n`=0 overrides all handshakes.
- `out_ready` held 0 indefinitely:
  - The pipeline fills to 4 entries, then `in_ready` stays 0.
  - Nothing is dropped or duplicated.

Test Plan:
1. All products = 256, bias = 0, relu = 0, `out_ready`=1 → 4 cycles after acceptance `pixel_out`=9 (2304>>8), `sat_out`=0.
2. Rounding: sums of 384 and -384 (p0 = ±384, others 0) → `pixel_out` = 2 and -1 respectively; a sum of 127 → 0.
3. Saturation and ReLU:
   - All products = 0x7FFFFFFF, bias = 0x7FFFFFFF → 32767, `sat_out`=1.
   - All products = 0x80000000 → -32768, `sat_out`=1.
   - The same negative input with relu = 1 → 0.
4. Backpressure: stream 8 distinct pixels with `out_ready` toggling 1,0,0,1,… → every pixel appears exactly once, in order. `pixel_out` is stable while stalled; `in_ready`=0 once 4 are held.
5. Frame counting with `NUM_OUT`=4: 5 accepted pixels → `done` pulses once, the cycle after the 4th handshake. `pix_cnt` reads 1,2,3,0,1.
6. Reset mid-stream:
   - Assert `rst_n`=0 for one cycle with 3 pixels in flight → `out_valid`=0 next cycle; no stale pixel emerges.
   - `pix_cnt`=0.
   - The next accepted pixel exits after 4 cycles.

Source files
------------

// File: rtl/conv_acc_stage_if.sv
// Handshake bundle between the multiplier PE, the accumulate stage and the
// output writer. master = upstream/downstream environment, slave = the stage.
interface conv_acc_stage_if #(
  parameter int CNT_W = 12
);
  logic             in_valid;
  logic             in_ready;
  logic [287:0]     product_in;
  logic [31:0]      bias_in;
  logic             relu_en;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      pixel_out;
  logic             sat_out;
  logic [CNT_W-1:0] pix_cnt;
  logic             done;

  modport master (
    output in_valid, product_in, bias_in, relu_en, out_ready,
    input  in_ready, out_valid, pixel_out, sat_out, pix_cnt, done
  );

  modport slave (
    input  in_valid, product_in, bias_in, relu_en, out_ready,
    output in_ready, out_valid, pixel_out, sat_out, pix_cnt, done
  );
endinterface

// File: rtl/conv_acc_stage.sv
// Accumulate stage behind the 9-tap multiplier PE: 4-deep adder-tree pipeline
// with bias, round/shift, saturate, optional ReLU, and a per-frame pixel
// counter. One global advance enable stalls the whole pipe under backpressure.

// One first-level pair adder: sign-extends two 32-bit products to 33 bits.
module conv_acc_pair (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [32:0] sum
);
  assign sum = {a[31], a} + {b[31], b};
endmodule

module conv_acc_stage #(
  parameter int SHIFT   = 8,
  parameter int NUM_OUT = 4096,
  parameter int CNT_W   = 12
) (
  input logic             clk,
  input logic             rst_n,
  conv_acc_stage_if.slave bus
);
  localparam int STAGES = 4;
  // Rounding constant 2^(SHIFT-1); zero when no shift is applied.
  localparam logic signed [37:0] RND_K =
    (SHIFT > 0) ? (38'sd1 <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : 38'sd0;

  typedef struct packed {
    logic [3:0][32:0] pair;
    logic [32:0]      pb;    // p8 + bias
    logic             relu;
  } s1_t;

  typedef struct packed {
    logic [1:0][33:0] quad;
    logic [32:0]      pb;
    logic             relu;
  } s2_t;

  typedef struct packed {
    logic [36:0] acc;
    logic        relu;
  } s3_t;

  logic [STAGES:1]  vld_pipe;
  logic             adv;
  logic [3:0][32:0] pair_sum;
  logic [32:0]      pb_sum;
  s1_t              s1_q;
  s2_t              s2_q;
  s3_t              s3_q;
  logic signed [37:0] acc_x;
  logic signed [37:0] rnd;
  logic [15:0]      pix_n;
  logic             sat_n;
  logic [15:0]      pix_q;
  logic             sat_q;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;
  logic             out_hs;

  // First tree level: products (2g, 2g+1) per adder lane.
  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_pair
      conv_acc_pair u_pair (
        .a   (bus.product_in[g*64 +: 32]),
        .b   (bus.product_in[g*64+32 +: 32]),
        .sum (pair_sum[g])
      );
    end
  endgenerate

  assign pb_sum = {bus.product_in[287], bus.product_in[287:256]}
                + {bus.bias_in[31], bus.bias_in};

  // Whole pipe moves only when the output slot is empty or being drained.
  assign adv          = ~vld_pipe[STAGES] | bus.out_ready;
  assign bus.in_ready = adv;
  assign out_hs       = vld_pipe[STAGES] & bus.out_ready;

  // Valid shift register; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (!rst_n)
      vld_pipe <= '0;
    else if (adv)
      vld_pipe <= {vld_pipe[STAGES-1:1], bus.in_valid};
  end

  // Adder-tree data stages S1..S3 (no reset needed, qualified by vld_pipe).
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_q.pair    <= pair_sum;
      s1_q.pb      <= pb_sum;
      s1_q.relu    <= bus.relu_en;
      s2_q.quad[0] <= {s1_q.pair[0][32], s1_q.pair[0]} + {s1_q.pair[1][32], s1_q.pair[1]};
      s2_q.quad[1] <= {s1_q.pair[2][32], s1_q.pair[2]} + {s1_q.pair[3][32], s1_q.pair[3]};
      s2_q.pb      <= s1_q.pb;
      s2_q.relu    <= s1_q.relu;
      s3_q.acc     <= {{3{s2_q.quad[0][33]}}, s2_q.quad[0]}
                    + {{3{s2_q.quad[1][33]}}, s2_q.quad[1]}
                    + {{4{s2_q.pb[32]}}, s2_q.pb};
      s3_q.relu    <= s2_q.relu;
    end
  end

  // Round half up, rescale, saturate to int16, then optional ReLU.
  always_comb begin
    acc_x = $signed({s3_q.acc[36], s3_q.acc});
    rnd   = (acc_x + RND_K) >>> SHIFT;
    sat_n = 1'b0;
    pix_n = rnd[15:0];
    if (rnd > 38'sd32767) begin
      pix_n = 16'h7FFF;
      sat_n = 1'b1;
    end else if (rnd < -38'sd32768) begin
      pix_n = 16'h8000;
      sat_n = 1'b1;
    end
    if (s3_q.relu && pix_n[15])
      pix_n = 16'h0000;
  end

  // Output register S4; held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_q <= '0;
      sat_q <= 1'b0;
    end else if (adv) begin
      pix_q <= pix_n;
      sat_q <= sat_n;
    end
  end

  // Frame pixel counter; done pulses the cycle after the last handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (out_hs) begin
        if (cnt_q == CNT_W'(NUM_OUT - 1)) begin
          cnt_q  <= '0;
          done_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.pixel_out = pix_q;
  assign bus.sat_out   = sat_q;
  assign bus.pix_cnt   = cnt_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_conv_acc_stage.sv
// Bench for conv_acc_stage: directed cases from the block's rules plus random
// traffic, all compared against an arithmetic reference and an ordered
// scoreboard that tracks how far each accepted pixel has travelled.
module tb_conv_acc_stage;
  localparam int SHIFT   = 8;
  localparam int NUM_OUT = 4;
  localparam int CNT_W   = 3;

  typedef struct {
    logic [15:0] pix;
    logic        sat;
    int          stg;
  } item_t;

  logic clk = 1'b0;
  logic rst_n;
  conv_acc_stage_if #(.CNT_W(CNT_W)) ifc ();

  conv_acc_stage #(.SHIFT(SHIFT), .NUM_OUT(NUM_OUT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  item_t       q[$];
  int          cnt_m = 0;
  bit          done_m = 1'b0;
  int          done_cnt = 0;
  logic [15:0] last_pix;
  logic        last_sat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference result from plain integer arithmetic.
  function automatic logic [16:0] ref_pix(logic [287:0] p, logic [31:0] b, bit relu);
    longint s;
    logic [31:0] w;
    bit sat;
    s = longint'($signed(b));
    for (int i = 0; i < 9; i++) begin
      w = p[i*32 +: 32];
      s += longint'($signed(w));
    end
    s = (s + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
    sat = 1'b0;
    if (s > 32767) begin s = 32767; sat = 1'b1; end
    else if (s < -32768) begin s = -32768; sat = 1'b1; end
    if (relu && s < 0) s = 0;
    return {sat, s[15:0]};
  endfunction

  // One clock cycle: drive, check against the model, update the model.
  task automatic step(input bit iv, input logic [287:0] prod, input logic [31:0] b,
                      input bit relu, input bit ordy, output bit acc);
    bit exp_ov, exp_ir, hs;
    logic [16:0] r;
    item_t it;
    @(negedge clk);
    rst_n = 1'b1;
    ifc.in_valid = iv; ifc.product_in = prod; ifc.bias_in = b;
    ifc.relu_en = relu; ifc.out_ready = ordy;
    #1;
    exp_ov = (q.size() > 0) && (q[0].stg == 4);
    exp_ir = !exp_ov || ordy;
    chk("out_valid", 64'(ifc.out_valid), 64'(exp_ov));
    chk("in_ready", 64'(ifc.in_ready), 64'(exp_ir));
    chk("pix_cnt", 64'(ifc.pix_cnt), 64'(cnt_m));
    chk("done", 64'(ifc.done), 64'(done_m));
    if (ifc.done) done_cnt++;
    if (exp_ov) begin
      chk("pixel", 64'(ifc.pixel_out), 64'(q[0].pix));
      chk("sat", 64'(ifc.sat_out), 64'(q[0].sat));
    end
    hs  = exp_ov && ordy;
    acc = iv && exp_ir;
    done_m = hs && (cnt_m == NUM_OUT - 1);
    if (hs) begin
      last_pix = ifc.pixel_out;
      last_sat = ifc.sat_out;
      cnt_m = (cnt_m + 1) % NUM_OUT;
      void'(q.pop_front());
    end
    if (exp_ir)
      foreach (q[i]) q[i].stg++;
    if (acc) begin
      r = ref_pix(prod, b, relu);
      it.pix = r[15:0]; it.sat = r[16]; it.stg = 1;
      q.push_back(it);
    end
    @(posedge clk);
  endtask

  // Reset pulse, then check every reset value on the following cycle.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; ifc.in_valid = 1'b0; ifc.out_ready = 1'b1;
    @(posedge clk);
    q.delete(); cnt_m = 0; done_m = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", 64'(ifc.out_valid), 64'd0);
    chk("rst_pixel", 64'(ifc.pixel_out), 64'd0);
    chk("rst_sat", 64'(ifc.sat_out), 64'd0);
    chk("rst_pix_cnt", 64'(ifc.pix_cnt), 64'd0);
    chk("rst_done", 64'(ifc.done), 64'd0);
    @(posedge clk);
  endtask

  function automatic logic [287:0] fill(logic [31:0] v);
    logic [287:0] p;
    for (int i = 0; i < 9; i++) p[i*32 +: 32] = v;
    return p;
  endfunction

  function automatic logic [287:0] only_p0(logic [31:0] v);
    logic [287:0] p;
    p = '0;
    p[31:0] = v;
    return p;
  endfunction

  // Single pixel, then drain; the pixel leaves on the 4th bubble cycle.
  task automatic one_pix(input string tag, input logic [287:0] p, input logic [31:0] b,
                         input bit relu, input logic [15:0] ep, input bit es);
    bit a;
    step(1'b1, p, b, relu, 1'b1, a);
    chk({tag, "_acc"}, 64'(a), 64'd1);
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b0, 1'b1, a);
    chk({tag, "_pix"}, 64'(last_pix), 64'(ep));
    chk({tag, "_sat"}, 64'(last_sat), 64'(es));
  endtask

  initial begin
    bit a;
    int k;
    bit pat[4];
    logic [287:0] p;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    rst_n = 1'b0;
    ifc.in_valid = 1'b0; ifc.product_in = '0; ifc.bias_in = '0;
    ifc.relu_en = 1'b0; ifc.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    do_reset();

    // Basic sum, rounding, saturation, relu.
    one_pix("t1", fill(32'd256), 32'd0, 1'b0, 16'd9, 1'b0);
    one_pix("rnd_pos", only_p0(32'd384), 32'd0, 1'b0, 16'd2, 1'b0);
    one_pix("rnd_neg", only_p0(-32'sd384), 32'd0, 1'b0, 16'hFFFF, 1'b0);
    one_pix("rnd_127", only_p0(32'd127), 32'd0, 1'b0, 16'd0, 1'b0);
    one_pix("sat_pos", fill(32'h7FFFFFFF), 32'h7FFFFFFF, 1'b0, 16'h7FFF, 1'b1);
    one_pix("sat_neg", fill(32'h80000000), 32'd0, 1'b0, 16'h8000, 1'b1);
    one_pix("relu_neg", fill(32'h80000000), 32'd0, 1'b1, 16'h0000, 1'b1);
    one_pix("bias", only_p0(32'd512), -32'sd1024, 1'b0, 16'hFFFE, 1'b0);

    // Backpressure: 8 distinct pixels with out_ready 1,0,0,1,...
    k = 0;
    for (int n = 0; n < 60 && k < 8; n++) begin
      step(1'b1, only_p0(32'((k + 1) * 256)), 32'd0, 1'b0, pat[n % 4], a);
      if (a) k++;
    end
    chk("bp_all_accepted", 64'(k), 64'd8);
    for (int n = 0; n < 10; n++) step(1'b1, only_p0(32'd25600), 32'd0, 1'b0, 1'b0, a);
    @(negedge clk);
    #1;
    chk("bp_full_in_ready", 64'(ifc.in_ready), 64'd0);
    chk("bp_full_out_valid", 64'(ifc.out_valid), 64'd1);
    for (int n = 0; n < 12; n++) step(1'b0, '0, '0, 1'b0, 1'b1, a);
    chk("bp_drained", 64'(q.size()), 64'd0);

    // Frame counting: 5 pixels, one done pulse, counter ends at 1.
    do_reset();
    done_cnt = 0;
    for (int n = 0; n < 5; n++) step(1'b1, only_p0(32'(n * 256)), 32'd0, 1'b0, 1'b1, a);
    for (int n = 0; n < 6; n++) step(1'b0, '0, '0, 1'b0, 1'b1, a);
    chk("frame_done_cnt", 64'(done_cnt), 64'd1);
    chk("frame_pix_cnt", 64'(ifc.pix_cnt), 64'd1);

    // Reset mid-stream with 3 pixels in flight.
    for (int n = 0; n < 3; n++) step(1'b1, only_p0(32'd1280), 32'd0, 1'b0, 1'b1, a);
    do_reset();
    for (int n = 0; n < 5; n++) step(1'b0, '0, '0, 1'b0, 1'b1, a);
    one_pix("post_rst", only_p0(32'd768), 32'd0, 1'b0, 16'd3, 1'b0);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 9; i++)
        p[i*32 +: 32] = ($urandom_range(0, 7) == 0) ? $urandom
                                                    : 32'($urandom_range(0, 200000)) - 32'd100000;
      step($urandom_range(0, 3) != 0, p, 32'($urandom_range(0, 20000)) - 32'd10000,
           1'($urandom_range(0, 1)), $urandom_range(0, 2) != 0, a);
    end
    for (int n = 0; n < 12; n++) step(1'b0, '0, '0, 1'b0, 1'b1, a);
    chk("rand_drained", 64'(q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
